nmi_copy_master: RTL and testbench

NMI initiator that moves blocks of words between NMI responders (memories, peripherals) without CPU involvement. On a `start` pulse it either copies `len_words` words from `src_addr` to `dst_addr` (read then write, one word at a time) or fills the destination with a constant. It sits on the master side of the NMI interconnect, next to the CPU, and drives the same valid/ready/addr/wdata/wstrb/rdata protocol that NMI memories respond to.

---
 rtl/nmi_copy_master.sv | 187 ++++++++++++++++++
 tb/tb_nmi_copy_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nmi_copy_master.sv
// NMI block-copy / fill initiator.
// Moves len_words words from src_addr to dst_addr (read then write per word), or writes a
// constant pattern to the destination, driving the NMI valid/ready master protocol.
// All bus and status outputs are decoded straight from flops (state and latched fields).

module nmi_copy_master #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned TIMEOUT     = 256,
    parameter int unsigned WSTRB_WIDTH = (DATA_WIDTH - 1) / 8 + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [LEN_WIDTH-1:0]   len_words,
    input  logic [DATA_WIDTH-1:0]  fill_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [LEN_WIDTH-1:0]   xfer_count,
    output logic                   m_nmi_valid,
    output logic                   m_nmi_instr,
    input  logic                   m_nmi_ready,
    output logic [ADDR_WIDTH-1:0]  m_nmi_addr,
    output logic [DATA_WIDTH-1:0]  m_nmi_wdata,
    output logic [WSTRB_WIDTH-1:0] m_nmi_wstrb,
    input  logic [DATA_WIDTH-1:0]  m_nmi_rdata
);

    // Counter only needs to hold values up to TIMEOUT-1.
    localparam int unsigned TO_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WSTRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(WSTRB_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]  src_q, src_d;
    logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [LEN_WIDTH-1:0]   xfer_q, xfer_d;
    logic                   error_q, error_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
    logic                   to_hit;

    // Current stall would be the TIMEOUT-th consecutive one.
    assign to_hit = (TIMEOUT != 0) && ((32'(to_cnt_q) + 32'd1) == TIMEOUT);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command fields, data holding register, progress and timeout counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            xfer_q   <= '0;
            error_q  <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            data_q   <= data_d;
            xfer_q   <= xfer_d;
            error_q  <= error_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state and datapath updates; the stall counter clears unless explicitly advanced.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        data_d   = data_q;
        xfer_d   = xfer_q;
        error_d  = error_q;
        to_cnt_d = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    src_d   = src_addr & ADDR_MASK;
                    dst_d   = dst_addr & ADDR_MASK;
                    len_d   = len_words;
                    data_d  = fill_data;
                    xfer_d  = '0;
                    error_d = 1'b0;
                    if (len_words == '0) begin
                        state_d = StFin;
                    end else if (mode) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (m_nmi_ready) begin
                    data_d  = m_nmi_rdata;
                    src_d   = src_q + ADDR_STEP;
                    state_d = StWr;
                end else if (to_hit) begin
                    error_d = 1'b1;
                    state_d = StFin;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            StWr: begin
                if (m_nmi_ready) begin
                    dst_d  = dst_q + ADDR_STEP;
                    xfer_d = xfer_q + LEN_WIDTH'(1);
                    if (xfer_d == len_q) begin
                        state_d = StFin;
                    end else if (!mode_q) begin
                        state_d = StRd;
                    end
                end else if (to_hit) begin
                    error_d = 1'b1;
                    state_d = StFin;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus and status outputs decoded from state; address/data held stable while stalled.
    always_comb begin
        m_nmi_valid = 1'b0;
        m_nmi_addr  = '0;
        m_nmi_wdata = '0;
        m_nmi_wstrb = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            StRd: begin
                m_nmi_valid = 1'b1;
                m_nmi_addr  = src_q;
                busy        = 1'b1;
            end
            StWr: begin
                m_nmi_valid = 1'b1;
                m_nmi_addr  = dst_q;
                m_nmi_wdata = data_q;
                m_nmi_wstrb = '1;
                busy        = 1'b1;
            end
            StFin: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign m_nmi_instr = 1'b0;
    assign error       = error_q;
    assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_nmi_copy_master.sv
// Self-checking bench for nmi_copy_master: directed and randomized copy/fill commands
// against a word-level memory model with configurable responder stall behaviour.

module tb_nmi_copy_master;

    localparam int unsigned TO = 8;

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        start      = 1'b0;
    logic        mode       = 1'b0;
    logic [31:0] src_addr   = '0;
    logic [31:0] dst_addr   = '0;
    logic [15:0] len_words  = '0;
    logic [31:0] fill_data  = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] xfer_count;
    logic        m_nmi_valid;
    logic        m_nmi_instr;
    logic        m_nmi_ready = 1'b0;
    logic [31:0] m_nmi_addr;
    logic [31:0] m_nmi_wdata;
    logic [3:0]  m_nmi_wstrb;
    logic [31:0] m_nmi_rdata;

    int errors = 0;
    int checks = 0;

    // Responder memory: 1024 words covering byte addresses 0x000..0xFFF.
    logic [31:0] mem [1024];
    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    bit          klog [$];

    always #5 clk = ~clk;

    assign m_nmi_rdata = mem[m_nmi_addr[11:2]];

    nmi_copy_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len_words   (len_words),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .xfer_count  (xfer_count),
        .m_nmi_valid (m_nmi_valid),
        .m_nmi_instr (m_nmi_instr),
        .m_nmi_ready (m_nmi_ready),
        .m_nmi_addr  (m_nmi_addr),
        .m_nmi_wdata (m_nmi_wdata),
        .m_nmi_wstrb (m_nmi_wstrb),
        .m_nmi_rdata (m_nmi_rdata)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pol: 0 always ready, 1 random stalls (max 5 in a row), 2 never ready on writes,
    // 3 three stall cycles on the second read. inj_cyc: cycle for a stray start (0 = none).
    task automatic run_cmd(input bit md, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [31:0] fd, input int pol,
                           input int inj_cyc, input bit exp_to, input string tag);
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] exp_data [$];
        logic [67:0] prev_req;
        int          stalls, cs, rd_idx, rd_stall, done_cyc, exp_done, nk, nw;
        bit          rdy, prev_st, have_done, proto_bad, stab_bad, seq_bad;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        stalls = 0; cs = 0; rd_idx = 0; rd_stall = 0; done_cyc = 0;
        prev_st = 1'b0; have_done = 1'b0; proto_bad = 1'b0; stab_bad = 1'b0; seq_bad = 1'b0;
        prev_req = '0;
        wlog_addr.delete();
        wlog_data.delete();
        klog.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_data.push_back(md ? fd : mem[10'((sa >> 2) + 32'(i))]);
        end

        @(negedge clk);
        start = 1'b1; mode = md; src_addr = s; dst_addr = d; len_words = n; fill_data = fd;
        m_nmi_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 300 && !have_done; cyc++) begin
            if (cyc == inj_cyc) begin
                start = 1'b1; mode = ~md; src_addr = s ^ 32'h40; dst_addr = d ^ 32'h80;
                len_words = n + 16'd3; fill_data = ~fd;
            end else begin
                start = 1'b0;
            end
            if (m_nmi_instr !== 1'b0) proto_bad = 1'b1;
            if (done === 1'b1) begin
                have_done = 1'b1;
                done_cyc = cyc;
                if (busy !== 1'b0 || m_nmi_valid !== 1'b0) proto_bad = 1'b1;
                m_nmi_ready = 1'b0;
            end else begin
                if (busy !== (n != 0) || m_nmi_valid !== (n != 0)) proto_bad = 1'b1;
                if (m_nmi_valid && !(m_nmi_wstrb == 4'h0 || m_nmi_wstrb == 4'hF))
                    proto_bad = 1'b1;
                if (prev_st && {m_nmi_addr, m_nmi_wdata, m_nmi_wstrb} !== prev_req)
                    stab_bad = 1'b1;
                case (pol)
                    1:       rdy = (cs >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    2:       rdy = (m_nmi_wstrb == 4'h0);
                    3:       rdy = !(m_nmi_wstrb == 4'h0 && rd_idx == 1 && rd_stall < 3);
                    default: rdy = 1'b1;
                endcase
                m_nmi_ready = rdy;
                if (m_nmi_valid && !rdy) begin
                    stalls++;
                    cs++;
                    if (m_nmi_wstrb == 4'h0) rd_stall++;
                end else begin
                    cs = 0;
                end
                prev_st  = m_nmi_valid && !rdy;
                prev_req = {m_nmi_addr, m_nmi_wdata, m_nmi_wstrb};
                if (m_nmi_valid && rdy) begin
                    if (m_nmi_wstrb == 4'h0) begin
                        rd_idx++;
                        klog.push_back(1'b0);
                    end else begin
                        mem[m_nmi_addr[11:2]] = m_nmi_wdata;
                        wlog_addr.push_back(m_nmi_addr);
                        wlog_data.push_back(m_nmi_wdata);
                        klog.push_back(1'b1);
                    end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;

        check({tag, ":done_seen"}, 128'(have_done), 128'(1));
        if (n == 0)      exp_done = 1;
        else if (exp_to) exp_done = 2 + int'(TO);  // read at cycle 1, then TO stalled write cycles
        else             exp_done = (md ? int'(n) + 1 : 2 * int'(n) + 1) + stalls;
        check({tag, ":done_cycle"}, 128'(done_cyc), 128'(exp_done));
        if (exp_to) check({tag, ":stalled_cycles"}, 128'(stalls), 128'(TO));
        check({tag, ":protocol"}, 128'(proto_bad), 128'(0));
        check({tag, ":stable_while_stalled"}, 128'(stab_bad), 128'(0));
        check({tag, ":xfer_count"}, 128'(xfer_count), 128'(exp_to ? 16'd0 : n));
        check({tag, ":error"}, 128'(error), 128'(exp_to));
        check({tag, ":done_pulse"}, 128'({done, busy}), 128'(0));

        nk = (n == 0) ? 0 : exp_to ? 1 : (md ? int'(n) : 2 * int'(n));
        if (klog.size() != nk) seq_bad = 1'b1;
        for (int j = 0; j < klog.size(); j++) begin
            if (klog[j] != (md ? 1'b1 : (j % 2 == 1))) seq_bad = 1'b1;
        end
        check({tag, ":rd_wr_sequence"}, 128'(seq_bad), 128'(0));
        nw = exp_to ? 0 : int'(n);
        check({tag, ":n_writes"}, 128'(wlog_addr.size()), 128'(nw));
        for (int i = 0; i < nw && i < wlog_addr.size(); i++) begin
            check($sformatf("%s:waddr%0d", tag, i), 128'(wlog_addr[i]), 128'(da + 32'(4 * i)));
            check($sformatf("%s:wdata%0d", tag, i), 128'(wlog_data[i]), 128'(exp_data[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        for (int i = 0; i < 4; i++) mem[10'h40 + 10'(i)] = 32'hA0 + 32'(i);

        repeat (3) @(negedge clk);
        check("reset_state", 128'({m_nmi_valid, m_nmi_instr, m_nmi_addr, m_nmi_wdata,
                                   m_nmi_wstrb, busy, done, error, xfer_count}), 128'(0));
        rstn = 1'b1;

        run_cmd(1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, 0, 1'b0, "copy4");
        run_cmd(1'b1, 32'h13, 32'h40, 16'd3, 32'hDEADBEEF, 0, 0, 1'b0, "fill3");
        run_cmd(1'b0, 32'h100, 32'h300, 16'd0, 32'h0, 0, 0, 1'b0, "len0");
        run_cmd(1'b0, 32'h180, 32'h280, 16'd4, 32'h0, 3, 0, 1'b0, "rd_stall");
        run_cmd(1'b0, 32'h500, 32'hA00, 16'd2, 32'h0, 2, 0, 1'b1, "timeout");
        @(negedge clk);
        check("error_sticky_idle", 128'(error), 128'(1));

        for (int r = 0; r < 6; r++) begin
            run_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h3E0)),
                    32'($urandom_range(32'h800, 32'hBE0)), 16'($urandom_range(1, 8)),
                    $urandom(), 1, 0, 1'b0, $sformatf("rand%0d", r));
        end

        run_cmd(1'b0, 32'h600, 32'hB00, 16'd4, 32'h0, 0, 3, 1'b0, "ignore_start");

        // Assert reset while the second write of a copy is pending.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 32'h300; dst_addr = 32'h900; len_words = 16'd4;
        fill_data = 32'h0; m_nmi_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !(m_nmi_valid && m_nmi_wstrb != 4'h0 && xfer_count == 16'd1);
             k++) @(negedge clk);
        check("rst_setup_mid_write", 128'({m_nmi_valid, m_nmi_wstrb, xfer_count}),
              128'({1'b1, 4'hF, 16'd1}));
        m_nmi_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_async_outputs", 128'({m_nmi_valid, m_nmi_instr, m_nmi_addr, m_nmi_wdata,
                                         m_nmi_wstrb, busy, done, error, xfer_count}), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        run_cmd(1'b1, 32'h0, 32'hC00, 16'd5, 32'h5A5AA5A5, 1, 0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
